// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode, exception and memory-access definitions
package cpu_defs_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2,
        DISCARD   = 2'd3
    } mem_state_t;

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_size = SIZE_H;
            OP_LW, OP_SW:         op_size = SIZE_W;
            default:              op_size = SIZE_B;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        op_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                     (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - selects the addressed byte/half of a read word and extends it
module mem_load_ext
    import cpu_defs_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    output logic [31:0] data32
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            OP_LB:   data32 = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data32 = {24'd0, byte_sel};
            OP_LH:   data32 = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data32 = {16'd0, half_sel};
            default: data32 = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit driving an SRAM-like request/addr_ok/data_ok bus
module mem_access
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              memen_i,
    input  logic              rmem_i,
    input  logic              wmem_i,
    input  logic [5:0]        op_i,
    input  logic [31:0]       aluout_i,
    input  logic [31:0]       rdata2_i,
    input  logic [7:0]        except_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              stall_o,
    output logic [7:0]        except_o,
    output logic [31:0]       badvaddr_o
);

    mem_state_t  state;
    mem_state_t  state_nxt;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        adel;
    logic        ades;
    logic        access_valid;
    logic [31:0] ext_data;

    always_comb begin
        is_half    = (op_size(op_i) == SIZE_H);
        is_word    = (op_size(op_i) == SIZE_W);
        misaligned = (is_half && aluout_i[0]) || (is_word && (aluout_i[1:0] != 2'b00));
        adel       = memen_i && rmem_i && misaligned;
        ades       = memen_i && wmem_i && misaligned;

        except_o           = except_i;
        except_o[EXC_ADEL] = except_i[EXC_ADEL] | adel;
        except_o[EXC_ADES] = except_i[EXC_ADES] | ades;
        badvaddr_o         = (adel || ades) ? aluout_i : 32'd0;
    end

    // Any pending exception (ours or upstream) or a flush suppresses the bus access.
    assign access_valid = memen_i && (except_o == 8'd0) && !flush_i;

    assign data_addr_o = aluout_i[ADDR_W-1:0];
    assign data_size_o = op_size(op_i);

    always_comb begin
        case (op_size(op_i))
            SIZE_B:  data_wdata_o = {4{rdata2_i[7:0]}};
            SIZE_H:  data_wdata_o = {2{rdata2_i[15:0]}};
            default: data_wdata_o = rdata2_i;
        endcase
    end

    mem_load_ext u_load_ext (
        .rdata  (data_rdata_i[31:0]),
        .op     (op_q),
        .offset (off_q),
        .data32 (ext_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access_valid && data_addr_ok_i) state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (data_data_ok_i && flush_i) state_nxt = IDLE;
                else if (data_data_ok_i)       state_nxt = DONE;
                else if (flush_i)              state_nxt = DISCARD;
            end
            DONE: begin
                if (flush_i || !stall_i) state_nxt = IDLE;
            end
            DISCARD: begin
                if (data_data_ok_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req_o = 1'b0;
        data_wr_o  = 1'b0;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                data_req_o = access_valid;
                data_wr_o  = wmem_i;
                stall_o    = access_valid;
            end
            WAIT_DATA: stall_o = 1'b1;
            DISCARD:   stall_o = memen_i;
            default:   stall_o = 1'b0;
        endcase
    end

    // The extender works on the op/offset captured at address accept, not the live pipeline inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q        <= 6'd0;
            off_q       <= 2'd0;
            load_data_o <= 32'd0;
        end else begin
            if ((state == IDLE) && access_valid && data_addr_ok_i) begin
                op_q  <= op_i;
                off_q <= aluout_i[1:0];
            end
            if ((state == WAIT_DATA) && data_data_ok_i && !flush_i && op_is_load(op_q)) begin
                load_data_o <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access acting as the data-bus slave
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        stall_i;
    logic        memen_i;
    logic        rmem_i;
    logic        wmem_i;
    logic [5:0]  op_i;
    logic [31:0] aluout_i;
    logic [31:0] rdata2_i;
    logic [7:0]  except_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic [7:0]  except_o;
    logic [31:0] badvaddr_o;

    always #5 clk_i = ~clk_i;

    mem_access dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .memen_i        (memen_i),
        .rmem_i         (rmem_i),
        .wmem_i         (wmem_i),
        .op_i           (op_i),
        .aluout_i       (aluout_i),
        .rdata2_i       (rdata2_i),
        .except_i       (except_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .load_data_o    (load_data_o),
        .stall_o        (stall_o),
        .except_o       (except_o),
        .badvaddr_o     (badvaddr_o)
    );

    typedef struct {
        logic [5:0]  op;
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] load;
        logic [7:0]  exc;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_lw(input logic [31:0] a);
        memen_i  = 1'b1;
        rmem_i   = 1'b1;
        wmem_i   = 1'b0;
        op_i     = 6'b100011;
        aluout_i = a;
    endtask

    task automatic idle_bus();
        memen_i = 1'b0;
        rmem_i  = 1'b0;
        wmem_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int nstall;
        int nbad;
        int t;

        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        memen_i = 1'b0; rmem_i = 1'b0; wmem_i = 1'b0;
        op_i = 6'd0; aluout_i = 32'd0; rdata2_i = 32'd0; except_i = 8'd0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'd0;

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_load", load_data_o, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        chk("reset_req", {31'd0, data_req_o}, 32'd0);

        //          op          ld    addr          wd            rd            dly size  wdata         load          exc
        vecs[0]  = '{6'b100011, 1'b1, 32'h00001000, 32'h11223344, 32'hDEADBEEF, 0, 2'd2, 32'h11223344, 32'hDEADBEEF, 8'h00};
        vecs[1]  = '{6'b100000, 1'b1, 32'h00001003, 32'h00000000, 32'h80FFFFFF, 1, 2'd0, 32'h00000000, 32'hFFFFFF80, 8'h00};
        vecs[2]  = '{6'b100100, 1'b1, 32'h00001003, 32'h00000000, 32'h80FFFFFF, 0, 2'd0, 32'h00000000, 32'h00000080, 8'h00};
        vecs[3]  = '{6'b101001, 1'b0, 32'h00002002, 32'h00001234, 32'hFFFFFFFF, 3, 2'd1, 32'h12341234, 32'h00000080, 8'h00};
        vecs[4]  = '{6'b100001, 1'b1, 32'h00003001, 32'h00000000, 32'h00000000, 0, 2'd1, 32'h00000000, 32'h00000000, 8'h10};
        vecs[5]  = '{6'b101011, 1'b0, 32'h00003002, 32'h00000000, 32'h00000000, 0, 2'd2, 32'h00000000, 32'h00000000, 8'h20};
        vecs[6]  = '{6'b100001, 1'b1, 32'h00001002, 32'h00000000, 32'h80017FFF, 2, 2'd1, 32'h00000000, 32'hFFFF8001, 8'h00};
        vecs[7]  = '{6'b100101, 1'b1, 32'h00001000, 32'h00000000, 32'h8001F00D, 0, 2'd1, 32'h00000000, 32'h0000F00D, 8'h00};
        vecs[8]  = '{6'b101000, 1'b0, 32'h00000001, 32'hAABBCCDD, 32'h12345678, 1, 2'd0, 32'hDDDDDDDD, 32'h0000F00D, 8'h00};
        vecs[9]  = '{6'b100000, 1'b1, 32'h00000002, 32'h00000000, 32'h12345678, 0, 2'd0, 32'h00000000, 32'h00000034, 8'h00};
        vecs[10] = '{6'b100101, 1'b1, 32'h00000003, 32'h00000000, 32'h00000000, 0, 2'd1, 32'h00000000, 32'h00000000, 8'h10};
        vecs[11] = '{6'b101011, 1'b0, 32'h00000004, 32'hCAFEBABE, 32'h00000000, 0, 2'd2, 32'hCAFEBABE, 32'h00000034, 8'h00};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            memen_i = 1'b1; rmem_i = vecs[i].is_load; wmem_i = !vecs[i].is_load;
            op_i = vecs[i].op; aluout_i = vecs[i].addr; rdata2_i = vecs[i].wd;
            data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
            #1;
            chk($sformatf("v%0d_except", i), {24'd0, except_o}, {24'd0, vecs[i].exc});
            if (vecs[i].exc != 8'd0) begin
                chk($sformatf("v%0d_badvaddr", i), badvaddr_o, vecs[i].addr);
                chk($sformatf("v%0d_req_blocked", i), {31'd0, data_req_o}, 32'd0);
                chk($sformatf("v%0d_stall_blocked", i), {31'd0, stall_o}, 32'd0);
                idle_bus();
            end else begin
                chk($sformatf("v%0d_badvaddr", i), badvaddr_o, 32'd0);
                chk($sformatf("v%0d_size", i), {30'd0, data_size_o}, {30'd0, vecs[i].size});
                chk($sformatf("v%0d_wr", i), {31'd0, data_wr_o}, {31'd0, !vecs[i].is_load});
                nreq = 0; nstall = 0; nbad = 0;
                for (int c = 0; c <= vecs[i].dly; c++) begin
                    if (c > 0) begin
                        @(negedge clk_i);
                        #1;
                    end
                    nreq += int'(data_req_o);
                    nstall += int'(stall_o);
                    if (data_wdata_o !== vecs[i].wdata || data_addr_o !== vecs[i].addr) nbad++;
                    if (c == vecs[i].dly) data_addr_ok_i = 1'b1;
                end
                @(negedge clk_i);
                data_addr_ok_i = 1'b0;
                data_data_ok_i = 1'b1;
                data_rdata_i = vecs[i].rd;
                sb_q.push_back(vecs[i].load);
                #1;
                nreq += int'(data_req_o);
                nstall += int'(stall_o);
                @(negedge clk_i);
                data_data_ok_i = 1'b0;
                data_rdata_i = 32'hA5A5A5A5;
                #1;
                t = 0;
                while (stall_o && t < 4) begin
                    @(negedge clk_i);
                    #1;
                    t++;
                end
                chk($sformatf("v%0d_done_reached", i), {31'd0, stall_o}, 32'd0);
                sb_exp = sb_q.pop_front();
                chk($sformatf("v%0d_load_data", i), load_data_o, sb_exp);
                chk($sformatf("v%0d_req_cycles", i), nreq, vecs[i].dly + 1);
                chk($sformatf("v%0d_stall_cycles", i), nstall, vecs[i].dly + 2);
                chk($sformatf("v%0d_bus_stable", i), nbad, 0);
                idle_bus();
            end
        end

        // upstream exception and flush both block the request
        @(negedge clk_i);
        set_lw(32'h00001000); except_i = 8'h01;
        #1;
        chk("exc_pass", {24'd0, except_o}, 32'h00000001);
        chk("exc_no_req", {31'd0, data_req_o}, 32'd0);
        chk("exc_no_badv", badvaddr_o, 32'd0);
        except_i = 8'h00; flush_i = 1'b1;
        #1;
        chk("flush_no_req", {31'd0, data_req_o}, 32'd0);
        chk("flush_no_stall", {31'd0, stall_o}, 32'd0);
        flush_i = 1'b0; idle_bus();

        // flush in WAIT_DATA, response arrives two cycles later and is dropped
        @(negedge clk_i);
        set_lw(32'h00004000); data_addr_ok_i = 1'b1;
        #1;
        chk("fl_req", {31'd0, data_req_o}, 32'd1);
        @(negedge clk_i);
        data_addr_ok_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("fl_wait_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chk("fl_disc_stall", {31'd0, stall_o}, 32'd1);
        chk("fl_disc_req", {31'd0, data_req_o}, 32'd0);
        @(negedge clk_i);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h00000055;
        #1;
        chk("fl_disc_req2", {31'd0, data_req_o}, 32'd0);
        @(negedge clk_i);
        data_data_ok_i = 1'b0;
        #1;
        chk("fl_load_kept", load_data_o, 32'h00000034);
        chk("fl_idle_req", {31'd0, data_req_o}, 32'd1);
        idle_bus();

        // flush and data_ok together: straight back to IDLE, result not written
        @(negedge clk_i);
        set_lw(32'h00005000); data_addr_ok_i = 1'b1;
        @(negedge clk_i);
        data_addr_ok_i = 1'b0; flush_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h00000077;
        #1;
        chk("fd_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clk_i);
        flush_i = 1'b0; data_data_ok_i = 1'b0;
        #1;
        chk("fd_idle_req", {31'd0, data_req_o}, 32'd1);
        chk("fd_load_kept", load_data_o, 32'h00000034);
        idle_bus();

        // downstream stall holds DONE for three cycles
        @(negedge clk_i);
        set_lw(32'h00006000); data_addr_ok_i = 1'b1;
        @(negedge clk_i);
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        sb_q.push_back(32'hCAFEF00D);
        @(negedge clk_i);
        data_data_ok_i = 1'b0; stall_i = 1'b1;
        sb_exp = sb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st%0d_stall_o", k), {31'd0, stall_o}, 32'd0);
            chk($sformatf("st%0d_load", k), load_data_o, sb_exp);
            chk($sformatf("st%0d_no_req", k), {31'd0, data_req_o}, 32'd0);
            @(negedge clk_i);
        end
        stall_i = 1'b0;
        #1;
        chk("st_release_done", {31'd0, data_req_o}, 32'd0);
        @(negedge clk_i);
        #1;
        chk("st_idle_req", {31'd0, data_req_o}, 32'd1);
        chk("st_load_final", load_data_o, 32'hCAFEF00D);
        idle_bus();

        // reset in the middle of a transaction
        @(negedge clk_i);
        set_lw(32'h00007000); data_addr_ok_i = 1'b1;
        @(negedge clk_i);
        data_addr_ok_i = 1'b0; idle_bus(); rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mid_reset_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_reset_load", load_data_o, 32'd0);

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
